// File: rtl/ibus_pkg.sv
// ---------------------------------------------------------------------------
// ibus_pkg
// Shared definitions for the instruction-bus ROM controller:
//   - ibus_state_e    : controller state encoding (IDLE / WAIT / DONE)
//   - CNT_W           : width of the ROM access wait counter
//   - WAIT_CYCLES_MIN : smallest supported ROM access time in cycles
//   - WAIT_CYCLES_MAX : largest supported ROM access time in cycles
//                       (this is the largest value the counter can hold)
// ---------------------------------------------------------------------------
package ibus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } ibus_state_e;

    localparam int CNT_W           = 4;
    localparam int WAIT_CYCLES_MIN = 1;
    localparam int WAIT_CYCLES_MAX = 15;

endpackage

// File: rtl/ibus_rom_ctrl.sv
// ---------------------------------------------------------------------------
// ibus_rom_ctrl
// Instruction-bus front end for a slow, combinational-read ROM. The CPU fetch
// port is stalled while a word is fetched from the ROM. The result register
// ibus_rddata also acts as a one-word fetch buffer: a refetch of the same word
// completes without a stall.
//
// Parameters
//   WAIT_CYCLES     ROM access cycles per miss (1..15; values outside that
//                   range are clamped)
//   ADDR_WIDTH      byte-address bits decoded into the ROM
//
// Ports
//   clk              clock, rising edge
//   rst_n            synchronous active-low reset
//   ibus_address     CPU fetch byte address
//   ibus_read        fetch request, held until ibus_stall is low
//   ibus_write       write request; illegal here, so it is dropped
//   ibus_byteenable  ignored (full-word fetches only)
//   icache_inv       one-cycle pulse that invalidates the fetch buffer
//   ibus_rddata      registered fetch data / fetch buffer contents
//   ibus_stall       combinational; high while a request is outstanding
//   rom_addr         registered ROM word address
//   rom_data         ROM read data for rom_addr
//   err_abort        one-cycle pulse when a fetch is abandoned
//   err_write        one-cycle pulse when a write is dropped
// ---------------------------------------------------------------------------
module ibus_rom_ctrl
    import ibus_pkg::*;
#(
    parameter int WAIT_CYCLES = 4,
    parameter int ADDR_WIDTH  = 13
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           ibus_address,
    input  logic                  ibus_read,
    input  logic                  ibus_write,
    input  logic [3:0]            ibus_byteenable,
    input  logic                  icache_inv,
    output logic [31:0]           ibus_rddata,
    output logic                  ibus_stall,
    output logic [ADDR_WIDTH-3:0] rom_addr,
    input  logic [31:0]           rom_data,
    output logic                  err_abort,
    output logic                  err_write
);

    // Keep the access time within what the 4-bit counter can express.
    localparam int WC = (WAIT_CYCLES < WAIT_CYCLES_MIN) ? WAIT_CYCLES_MIN :
                        (WAIT_CYCLES > WAIT_CYCLES_MAX) ? WAIT_CYCLES_MAX :
                        WAIT_CYCLES;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WC - 1);

    ibus_state_e      state;
    logic [CNT_W-1:0] cnt;
    logic [29:0]      tag;
    logic             buf_valid;

    logic [29:0]      req_tag;
    logic             hit;

    // Byte lanes and the sub-word address bits carry no information for a
    // full-word fetch.
    logic             unused_bits;
    assign unused_bits = ^{ibus_byteenable, ibus_address[1:0]};

    // The full upper address takes part in the tag compare even though only
    // ADDR_WIDTH bits reach the ROM, so aliased addresses never hit each
    // other's buffer contents. An invalidate in the same cycle kills the hit.
    assign req_tag = ibus_address[31:2];
    assign hit     = buf_valid && (tag == req_tag) && !icache_inv;

    always_comb begin
        ibus_stall = 1'b0;
        if (ibus_read && !ibus_write) begin
            case (state)
                IDLE:    ibus_stall = !hit;
                WAIT:    ibus_stall = 1'b1;
                default: ibus_stall = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            tag         <= '0;
            buf_valid   <= 1'b0;
            ibus_rddata <= '0;
            rom_addr    <= '0;
            err_abort   <= 1'b0;
            err_write   <= 1'b0;
        end else begin
            err_abort <= 1'b0;
            err_write <= 1'b0;

            // Invalidate affects only what is already in the buffer; a fill
            // completing on this same edge overrides it below.
            if (icache_inv) begin
                buf_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (ibus_write) begin
                        err_write <= 1'b1;
                    end else if (ibus_read && !hit) begin
                        rom_addr  <= ibus_address[ADDR_WIDTH-1:2];
                        tag       <= req_tag;
                        cnt       <= '0;
                        buf_valid <= 1'b0;
                        state     <= WAIT;
                    end
                end

                WAIT: begin
                    if (ibus_write || !ibus_read) begin
                        // Request withdrawn (or replaced by an illegal write):
                        // abandon the fill; the buffer stays invalid.
                        err_abort <= 1'b1;
                        err_write <= ibus_write;
                        state     <= IDLE;
                    end else if (req_tag != tag) begin
                        // CPU moved to a different word: restart the access.
                        err_abort <= 1'b1;
                        rom_addr  <= ibus_address[ADDR_WIDTH-1:2];
                        tag       <= req_tag;
                        cnt       <= '0;
                    end else if (cnt == CNT_LAST) begin
                        ibus_rddata <= rom_data;
                        buf_valid   <= 1'b1;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ibus_rom_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ibus_rom_ctrl
// Directed bench for ibus_rom_ctrl with WAIT_CYCLES=4, ADDR_WIDTH=13.
// ROM contents: word 0 = 0x3C010001, word n (n>0) = 0xC0DE0000 | n.
// ---------------------------------------------------------------------------
module tb_ibus_rom_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] ibus_address;
    logic        ibus_read;
    logic        ibus_write;
    logic [3:0]  ibus_byteenable;
    logic        icache_inv;
    logic [31:0] ibus_rddata;
    logic        ibus_stall;
    logic [10:0] rom_addr;
    logic [31:0] rom_data;
    logic        err_abort;
    logic        err_write;

    int checks = 0;
    int errors = 0;

    ibus_rom_ctrl #(
        .WAIT_CYCLES (4),
        .ADDR_WIDTH  (13)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ibus_address    (ibus_address),
        .ibus_read       (ibus_read),
        .ibus_write      (ibus_write),
        .ibus_byteenable (ibus_byteenable),
        .icache_inv      (icache_inv),
        .ibus_rddata     (ibus_rddata),
        .ibus_stall      (ibus_stall),
        .rom_addr        (rom_addr),
        .rom_data        (rom_data),
        .err_abort       (err_abort),
        .err_write       (err_write)
    );

    always #5 clk = ~clk;

    always_comb begin
        rom_data = 32'h0;
        if (rom_addr == 11'd0) rom_data = 32'h3C010001;
        else                   rom_data = {16'hC0DE, 5'd0, rom_addr};
    end

    task automatic check_eq(input string name, input logic [31:0] obs,
                            input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Count cycles with stall high, starting with the current one (bounded).
    task automatic count_stalls(output int n);
        n = 0;
        #1;
        while (ibus_stall === 1'b1 && n < 40) begin
            step();
            n++;
        end
    endtask

    task automatic fetch(input logic [31:0] a, input logic [31:0] exp_d,
                         input int exp_stalls, input string name);
        int n;
        ibus_address = a;
        ibus_read    = 1'b1;
        count_stalls(n);
        check_eq({name, ":stalls"}, n, exp_stalls);
        check_eq({name, ":data"}, ibus_rddata, exp_d);
        step();
        ibus_read = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n           = 1'b0;
        ibus_address    = 32'h0;
        ibus_read       = 1'b0;
        ibus_write      = 1'b0;
        ibus_byteenable = 4'hF;
        icache_inv      = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        #1;
        check_eq("rst:rddata",    ibus_rddata, 32'h0);
        check_eq("rst:rom_addr",  32'(rom_addr), 32'h0);
        check_eq("rst:stall",     32'(ibus_stall), 32'h0);
        check_eq("rst:err_abort", 32'(err_abort), 32'h0);
        check_eq("rst:err_write", 32'(err_write), 32'h0);

        // Basic miss, then buffer hit, then miss on the next word.
        fetch(32'h80000000, 32'h3C010001, 5, "miss0");
        check_eq("miss0:rom_addr", 32'(rom_addr), 32'd0);
        fetch(32'h80000000, 32'h3C010001, 0, "hit0");
        fetch(32'h80000004, 32'hC0DE0001, 5, "miss1");
        check_eq("miss1:rom_addr", 32'(rom_addr), 32'd1);

        // Read dropped in the 2nd WAIT cycle.
        ibus_address = 32'h80000008;
        ibus_read    = 1'b1;
        #1;
        check_eq("abort:idle_stall", 32'(ibus_stall), 32'd1);
        step();
        step();
        ibus_read = 1'b0;
        #1;
        check_eq("abort:stall_noreq", 32'(ibus_stall), 32'd0);
        step();
        check_eq("abort:pulse", 32'(err_abort), 32'd1);
        check_eq("abort:rddata_kept", ibus_rddata, 32'hC0DE0001);
        step();
        check_eq("abort:pulse_end", 32'(err_abort), 32'd0);
        fetch(32'h80000008, 32'hC0DE0002, 5, "refetch2");

        // Address change mid-WAIT restarts at the new word.
        ibus_address = 32'h8000000C;
        ibus_read    = 1'b1;
        step();
        step();
        ibus_address = 32'h80000010;
        step();
        check_eq("restart:pulse", 32'(err_abort), 32'd1);
        check_eq("restart:rom_addr", 32'(rom_addr), 32'd4);
        count_stalls(n);
        check_eq("restart:stalls", n, 4);
        check_eq("restart:data", ibus_rddata, 32'hC0DE0004);
        step();
        ibus_read = 1'b0;

        // Invalidate pulse forces a miss on a previously buffered word.
        fetch(32'h80000000, 32'h3C010001, 5, "fill0");
        icache_inv = 1'b1;
        step();
        icache_inv = 1'b0;
        fetch(32'h80000000, 32'h3C010001, 5, "inv_miss");
        fetch(32'h80000000, 32'h3C010001, 0, "inv_rehit");

        // Invalidate coincident with a would-be hit.
        ibus_address = 32'h80000000;
        ibus_read    = 1'b1;
        icache_inv   = 1'b1;
        #1;
        check_eq("inv_hit:stall", 32'(ibus_stall), 32'd1);
        step();
        icache_inv = 1'b0;
        count_stalls(n);
        check_eq("inv_hit:stalls", n, 4);
        check_eq("inv_hit:data", ibus_rddata, 32'h3C010001);
        step();
        ibus_read = 1'b0;

        // Writes are dropped without a stall and without touching state.
        ibus_address = 32'h80000010;
        ibus_write   = 1'b1;
        #1;
        check_eq("wr:stall", 32'(ibus_stall), 32'd0);
        step();
        check_eq("wr:pulse", 32'(err_write), 32'd1);
        ibus_read = 1'b1;
        #1;
        check_eq("wr_rd:stall", 32'(ibus_stall), 32'd0);
        step();
        check_eq("wr_rd:pulse", 32'(err_write), 32'd1);
        ibus_write = 1'b0;
        ibus_read  = 1'b0;
        step();
        check_eq("wr:pulse_end", 32'(err_write), 32'd0);
        check_eq("wr:rddata_kept", ibus_rddata, 32'h3C010001);
        fetch(32'h80000000, 32'h3C010001, 0, "wr_hit");

        // Upper address bits are tagged but alias onto the same ROM word.
        fetch(32'h00000000, 32'h3C010001, 5, "alias");
        check_eq("alias:rom_addr", 32'(rom_addr), 32'd0);

        // Reset in the 3rd WAIT cycle discards the fill.
        ibus_address = 32'h80000004;
        ibus_read    = 1'b1;
        step();
        step();
        step();
        rst_n     = 1'b0;
        ibus_read = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
        check_eq("midrst:rddata",    ibus_rddata, 32'h0);
        check_eq("midrst:rom_addr",  32'(rom_addr), 32'h0);
        check_eq("midrst:stall",     32'(ibus_stall), 32'h0);
        check_eq("midrst:err_abort", 32'(err_abort), 32'h0);
        check_eq("midrst:err_write", 32'(err_write), 32'h0);
        fetch(32'h80000004, 32'hC0DE0001, 5, "post_rst");
        check_eq("post_rst:rom_addr", 32'(rom_addr), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ibus_rom_ctrl.md
IBUS_ROM_CTRL -- requirements
Module: ibus_rom_ctrl

Interface
REQ-001 Parameter WAIT_CYCLES, default 4, ROM access cycles per miss; legal range 1..15.
REQ-002 Parameter ADDR_WIDTH, default 13, byte-address bits decoded into ROM.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 ibus_address  input  32  CPU fetch byte address.
REQ-006 ibus_read  input  1  CPU fetch request, held until stall low.
REQ-007 ibus_write  input  1  CPU write request; illegal on instruction bus.
REQ-008 ibus_byteenable  input  4  ignored; full-word fetch only.
REQ-009 icache_inv  input  1  one-cycle pulse invalidating fetch buffer.
REQ-010 ibus_rddata  output  32  registered fetch data, doubles as one-word fetch buffer.
REQ-011 ibus_stall  output  1  combinational; high while request not yet satisfied.
REQ-012 rom_addr  output  ADDR_WIDTH-2  registered ROM word address.
REQ-013 rom_data  input  32  ROM read data, combinational from rom_addr.
REQ-014 err_abort  output  1  one-cycle pulse on aborted fetch.
REQ-015 err_write  output  1  one-cycle pulse on dropped write.

Function
REQ-016 States SHALL be IDLE, WAIT, DONE; 4-bit wait counter; buffer tag register (address[31:2]) plus buf_valid bit.
REQ-017 Hit: IDLE, ibus_read=1, buf_valid=1, tag==ibus_address[31:2], icache_inv=0 -> ibus_stall=0 same cycle, ibus_rddata unchanged, state stays IDLE.
REQ-018 Miss in IDLE SHALL assert ibus_stall, load rom_addr<=ibus_address[ADDR_WIDTH-1:2], latch tag, clear counter, go WAIT.
REQ-019 WAIT SHALL hold ibus_stall=1 and increment counter each cycle; in the cycle counter==WAIT_CYCLES-1, ibus_rddata<=rom_data, buf_valid<=1, go DONE.
REQ-020 DONE SHALL drive ibus_stall=0 for exactly one cycle, then IDLE; miss latency: stall high WAIT_CYCLES+1 cycles, low on the next.
REQ-021 ibus_stall SHALL be 0 whenever ibus_read=0 and ibus_write=0.
REQ-022 ibus_read falling in WAIT SHALL pulse err_abort, go IDLE, leave buf_valid=0 and ibus_rddata unchanged.
REQ-023 ibus_address change (bits 31:2) while in WAIT with ibus_read=1 SHALL pulse err_abort and restart as a new miss at the new address next cycle.
REQ-024 ibus_write=1 in IDLE SHALL pulse err_write, keep ibus_stall=0, change no state; ibus_write=1 with ibus_read=1 treated as write.
REQ-025 icache_inv SHALL clear buf_valid next edge; simultaneous with a would-be hit -> treated as miss; during WAIT -> aborts nothing, but the fill completing sets buf_valid (inv applies only to prior contents).
REQ-026 Buffer miss SHALL invalidate buf_valid at entry to WAIT (mid-fill buffer never hits).
REQ-027 Address bits above ADDR_WIDTH SHALL be tag-compared but not sent to ROM (aliasing allowed).

Reset
REQ-028 rst_n=0 SHALL force state IDLE, counter 0, buf_valid 0, tag 0, ibus_rddata 0, rom_addr 0, err_abort 0, err_write 0.
REQ-029 Reset asserted mid-WAIT SHALL discard the fill; first fetch after reset SHALL be a miss.

Structure
REQ-030 Shared package ibus_pkg SHALL hold state enum (IDLE/WAIT/DONE), counter width constant 4, WAIT_CYCLES legal bounds.
REQ-031 Single module, no sub-module; ROM is external.

Verification
REQ-032 WAIT_CYCLES=4, fetch 0x80000000 (rom word 0 = 0x3C010001) -> stall high 5 cycles, low 6th, ibus_rddata=0x3C010001.
REQ-033 Immediate refetch 0x80000000 -> stall never asserted, ibus_rddata=0x3C010001; then 0x80000004 -> 5-cycle miss.
REQ-034 Drop ibus_read in 2nd WAIT cycle -> err_abort one-cycle pulse, refetch same address -> full 5-cycle miss.
REQ-035 icache_inv pulse, then fetch 0x80000000 -> full miss; ibus_write=1 at 0x80000010 -> err_write pulse, stall 0.
REQ-036 rst_n low for 1 cycle in 3rd WAIT cycle -> all outputs 0, next fetch full miss with correct data.
